// File: rtl/cnn_layer_sequencer.sv
// Layer sequencer: latches a layer command, streams weight beats into the filter FIFOs,
// buffers image beats through the PU, then runs conv/pool/FC. Optional CNN_SEQ_PERF_CNT_EN adds perf counters.
module cnn_layer_sequencer #(
    parameter int NUM_FIFOS = 32,
    parameter int EPB       = 2,
    parameter int DIM_W     = 6,
    parameter int IMG_BEATS = 68
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 start_i,
    input  logic [2:0]                           mode_i,
    input  logic [$clog2(NUM_FIFOS+1)-1:0]       num_filt_i,
    input  logic [DIM_W-1:0]                     weight_dim_i,
    input  logic                                 w_valid_i,
    output logic                                 w_ready_o,
    output logic [NUM_FIFOS-1:0]                 weight_en_o,
    output logic [DIM_W-1:0]                     weight_dim_o,
    input  logic                                 img_valid_i,
    output logic                                 pu_en_o,
    output logic                                 conv_en_o,
    output logic                                 pool_en_o,
    output logic                                 fc_en_o,
    input  logic                                 pu_finish_i,
    input  logic                                 conv_finish_i,
    input  logic                                 pool_finish_i,
    input  logic                                 fc_finish_i,
    output logic                                 busy_o,
    output logic                                 done_o,
`ifdef CNN_SEQ_PERF_CNT_EN
    output logic [31:0]                          cycles_o,
    output logic [31:0]                          stall_cycles_o,
`endif
    output logic                                 err_o
);

    localparam int NF_W  = $clog2(NUM_FIFOS + 1);
    localparam int IMG_W = $clog2(IMG_BEATS + 1);
    localparam int BW    = DIM_W + 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD_W,
        S_LOAD_IMG,
        S_CONV,
        S_POOL,
        S_FC,
        S_DONE
    } state_t;

    state_t            state_q, state_d;
    logic [2:0]        mode_q;
    logic [NF_W-1:0]   num_filt_q;
    logic [DIM_W-1:0]  weight_dim_q;
    logic [BW-1:0]     beat_cnt_q;
    logic [NF_W-1:0]   filt_cnt_q;
    logic [IMG_W-1:0]  img_cnt_q;
    logic              pu_seen_q;
    logic              err_q;

    logic              is_conv_mode;
    logic              cmd_invalid;
    logic [BW-1:0]     beats_per_filt;
    logic              last_beat;
    logic              last_filt;
    logic              img_last;

    // Command validity is judged on the live inputs since it is decided in the accepting cycle.
    assign is_conv_mode = (mode_i == 3'b001) || (mode_i == 3'b010) || (mode_i == 3'b110);
    assign cmd_invalid  = (mode_i == 3'b000) || (mode_i == 3'b100) || (mode_i == 3'b101) ||
                          (is_conv_mode && ((num_filt_i == '0) ||
                                            (num_filt_i > NF_W'(NUM_FIFOS)) ||
                                            (weight_dim_i == '0)));

    assign beats_per_filt = ({1'b0, weight_dim_q} + BW'(EPB - 1)) / BW'(EPB);
    assign last_beat      = (beat_cnt_q == beats_per_filt - 1'b1);
    assign last_filt      = (filt_cnt_q == num_filt_q - 1'b1);
    assign img_last       = img_valid_i && (img_cnt_q == IMG_W'(IMG_BEATS - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        w_ready_o   = 1'b0;
        weight_en_o = '0;
        pu_en_o     = 1'b0;
        conv_en_o   = 1'b0;
        pool_en_o   = 1'b0;
        fc_en_o     = 1'b0;
        done_o      = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    if (cmd_invalid || (mode_i == 3'b111)) begin
                        state_d = S_DONE;
                    end else if (mode_i == 3'b011) begin
                        state_d = S_FC;
                    end else begin
                        state_d = S_LOAD_W;
                    end
                end
            end
            S_LOAD_W: begin
                w_ready_o   = 1'b1;
                weight_en_o = {{(NUM_FIFOS-1){1'b0}}, 1'b1} << filt_cnt_q;
                if (w_valid_i && last_beat && last_filt) begin
                    state_d = S_LOAD_IMG;
                end
            end
            S_LOAD_IMG: begin
                pu_en_o = 1'b1;
                if (img_last) begin
                    state_d = S_CONV;
                end
            end
            S_CONV: begin
                conv_en_o = 1'b1;
                pu_en_o   = !pu_seen_q;
                if (conv_finish_i) begin
                    state_d = (mode_q == 3'b001) ? S_DONE : S_POOL;
                end
            end
            S_POOL: begin
                pool_en_o = 1'b1;
                if (pool_finish_i) begin
                    state_d = (mode_q == 3'b010) ? S_DONE : S_FC;
                end
            end
            S_FC: begin
                fc_en_o = 1'b1;
                if (fc_finish_i) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                done_o  = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign busy_o       = (state_q != S_IDLE);
    assign weight_dim_o = weight_dim_q;
    assign err_o        = err_q;

    // Command latches, beat/filter/image counters and the sticky PU-finished flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mode_q       <= '0;
            num_filt_q   <= '0;
            weight_dim_q <= '0;
            beat_cnt_q   <= '0;
            filt_cnt_q   <= '0;
            img_cnt_q    <= '0;
            pu_seen_q    <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start_i) begin
                        mode_q       <= mode_i;
                        num_filt_q   <= num_filt_i;
                        weight_dim_q <= weight_dim_i;
                        beat_cnt_q   <= '0;
                        filt_cnt_q   <= '0;
                        img_cnt_q    <= '0;
                        pu_seen_q    <= 1'b0;
                        err_q        <= cmd_invalid;
                    end
                end
                S_LOAD_W: begin
                    if (w_valid_i) begin
                        if (last_beat) begin
                            beat_cnt_q <= '0;
                            filt_cnt_q <= filt_cnt_q + 1'b1;
                        end else begin
                            beat_cnt_q <= beat_cnt_q + 1'b1;
                        end
                    end
                end
                S_LOAD_IMG: begin
                    if (img_valid_i) begin
                        img_cnt_q <= img_cnt_q + 1'b1;
                    end
                    if (pu_finish_i) begin
                        pu_seen_q <= 1'b1;
                    end
                end
                S_CONV: begin
                    if (pu_finish_i) begin
                        pu_seen_q <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef CNN_SEQ_PERF_CNT_EN
    // Saturating performance counters, restarted by each accepted command.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cycles_o       <= '0;
            stall_cycles_o <= '0;
        end else if ((state_q == S_IDLE) && start_i) begin
            cycles_o       <= '0;
            stall_cycles_o <= '0;
        end else begin
            if ((state_q != S_IDLE) && (cycles_o != '1)) begin
                cycles_o <= cycles_o + 1'b1;
            end
            if ((state_q == S_LOAD_W) && !w_valid_i && (stall_cycles_o != '1)) begin
                stall_cycles_o <= stall_cycles_o + 1'b1;
            end
        end
    end
`endif

endmodule

// File: doc/cnn_layer_sequencer.md
# cnn_layer_sequencer

Top-level layer sequencer for the CNN accelerator and the parametrised successor of the current fixed-size controller. It latches a layer command and streams weight beats into up to NUM_FIFOS filter FIFOs with a valid/ready handshake. It then buffers IMG_BEATS image beats through the PU and runs the conv, pool and FC engines in sequence according to the mode. It sits between the AXI front end / command register and the PU, conv, pooling and FC controllers.

## Interface
- NUM_FIFOS, 32: number of filter FIFOs (max filters per layer).
- EPB, 2: weight elements delivered per accepted beat.
- DIM_W, 6: width of weight element count.
- IMG_BEATS, 68: image beats buffered before conv starts.
- clk  in  1  clock.
- rst  in  1  asynchronous, active-high reset.
- start_i  in  1  command strobe; sampled only in IDLE.
- mode_i  in  3  000 none, 001 conv, 010 conv+pool, 110 conv+pool+FC, 011 FC only, 111 out (no-op).
- num_filt_i  in  $clog2(NUM_FIFOS+1)  filter count, latched on start.
- weight_dim_i  in  DIM_W  weight elements per filter, latched on start.
- w_valid_i / w_ready_o  in/out  1  weight beat handshake.
- weight_en_o  out  NUM_FIFOS  one-hot FIFO write enable; equals w_ready_o on the current filter bit.
- weight_dim_o  out  DIM_W  latched weight_dim.
- img_valid_i  in  1  image beat present.
- pu_en_o  out  1  PU enable.
- conv_en_o, pool_en_o, fc_en_o  out  1  engine enables.
- pu_finish_i, conv_finish_i, pool_finish_i, fc_finish_i  in  1  engine completion levels.
- busy_o  out  1  high in every state except IDLE.
- done_o  out  1  one-cycle pulse at end of command.
- err_o  out  1  sticky command error; cleared by the next accepted start.

## Operation
- States: IDLE, LOAD_W, LOAD_IMG, CONV, POOL, FC, DONE.
- IDLE + start_i: latch mode, num_filt and weight_dim; clear counters.
  - Invalid command goes to DONE with err_o=1 and no engine enable. Invalid means mode 000/100/101, or a conv mode with num_filt=0, num_filt>NUM_FIFOS or weight_dim=0.
  - Mode 111 goes to DONE. Mode 011 goes to FC. Conv modes go to LOAD_W.
- LOAD_W
  - beats per filter = ceil(weight_dim/EPB).
  - w_ready_o=1. Filter counter f selects weight_en_o[f].
  - A beat counts only when w_valid_i&w_ready_o.
  - The last beat of filter f advances f. The last beat of filter num_filt-1 goes to LOAD_IMG.
  - w_valid_i low stalls; no counter change.
- LOAD_IMG
  - pu_en_o=1. Count beats with img_valid_i.
  - The IMG_BEATS-th beat goes to CONV.
- CONV
  - conv_en_o=1.
  - pu_en_o=1 until pu_finish_i is seen once (sticky flag), then 0.
  - On conv_finish_i: mode 001 goes to DONE; other conv modes go to POOL.
- POOL: pool_en_o=1. On pool_finish_i: mode 010 goes to DONE, mode 110 goes to FC.
- FC: fc_en_o=1. On fc_finish_i, go to DONE.
- DONE: done_o=1 for one cycle, then IDLE.
- Counters are sized to their maxima; none wraps.

## Timing
- Reset is asynchronous: state=IDLE, counters=0, latches=0, err_o=0. All outputs are 0, including w_ready_o, weight_en_o, weight_dim_o and done_o.
- Reset mid-operation aborts immediately; no done_o pulse is produced.
- All outputs are registered-state decodes: an input seen in cycle N changes outputs in cycle N+1.
- Latencies:
  - start_i accepted at edge N: w_ready_o=1 in cycle N+1.
  - Last weight beat at edge M: pu_en_o=1 and w_ready_o=0 in cycle M+1.
  - A finish input high at edge K: next state's enable (or done_o) in cycle K+1.
- start_i outside IDLE is ignored.
- Finish inputs are ignored outside their own state.
- If img_valid_i is high in LOAD_W, it is not counted.
- If pu_finish_i arrives during LOAD_IMG, it sets the sticky flag.
- Minimal conv command (num_filt=1, dim=2, EPB=2, IMG_BEATS=68, no stalls, finishes immediate) takes 1 (LOAD_W) + 68 + 1 (CONV) + 1 (DONE) cycles after start.

## Configuration
- CNN_SEQ_PERF_CNT_EN defined: adds outputs cycles_o[31:0] and stall_cycles_o[31:0].
  - Both clear on accepted start and on reset, and saturate at all-ones.
  - cycles_o counts cycles with busy_o.
  - stall_cycles_o counts LOAD_W cycles with w_valid_i=0.
- CNN_SEQ_PERF_CNT_EN undefined: these ports and their logic do not exist; all other behaviour is identical.

## Test plan
- Mode 001, num_filt=3, weight_dim=5, EPB=2, w_valid always 1 -> 3 beats per filter; weight_en_o steps 0x1 (3 cycles), 0x2 (3), 0x4 (3); then 68 pu_en_o cycles, CONV, done_o.
- Same command with w_valid_i toggling every other cycle -> 9 accepted beats over 18 cycles; weight_en_o is unchanged while w_valid_i is low.
- Mode 110 with conv_finish_i, pool_finish_i and fc_finish_i each asserted 5 cycles into its state -> enables are mutually exclusive, ordered conv, pool, fc; done_o fires one cycle after fc_finish_i.
- num_filt=NUM_FIFOS+1, or mode 101 -> err_o=1 and done_o in cycle 2 with no enable asserted; a following valid start clears err_o.
- rst pulsed in the middle of LOAD_IMG -> all outputs 0 immediately; a subsequent start restarts from filter 0.
- With CNN_SEQ_PERF_CNT_EN, the first scenario gives cycles_o equal to the busy cycle count and stall_cycles_o=0.
